// File: rtl/rx_edge_bit_sampler_if.sv
// Bundle of the serial-line, control and sample-strobe signals between the RX FSM
// and the edge/bit sampler. The signal names match the legacy ports.
interface rx_edge_bit_sampler_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);
  logic                  RX_IN;
  logic                  enable;
  logic                  dat_samp_en;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  samp_valid;

  modport master (
    output RX_IN, enable, dat_samp_en, PAR_EN, prescale,
    input  edge_cnt, bit_cnt, sampled_bit, samp_valid
  );

  modport slave (
    input  RX_IN, enable, dat_samp_en, PAR_EN, prescale,
    output edge_cnt, bit_cnt, sampled_bit, samp_valid
  );
endinterface

// File: rtl/rx_edge_bit_sampler.sv
// Oversampling edge/bit counter with 3-sample majority vote around mid-bit.
// The prescale value is latched only while the frame is inactive.
module rx_edge_bit_sampler #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input logic                 CLK,
  input logic                 RST,
  rx_edge_bit_sampler_if.slave bus
);
  localparam logic [PRESCALE_W-1:0] PRE_MIN = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] ONE     = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO     = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] pre_l_q, pre_l_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  samp_valid_q, samp_valid_d;

  logic [PRESCALE_W-1:0] pre_sel;
  logic [PRESCALE_W-1:0] half;
  logic [BIT_CNT_W-1:0]  last_bit;

  always_comb begin
    pre_sel  = (bus.prescale < PRE_MIN) ? PRE_MIN : bus.prescale;
    half     = pre_l_q >> 1;
    last_bit = bus.PAR_EN ? BIT_CNT_W'(10) : BIT_CNT_W'(9);

    pre_l_d       = pre_l_q;
    edge_cnt_d    = edge_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    sampled_bit_d = sampled_bit_q;
    samp_valid_d  = 1'b0;

    if (!bus.enable) begin
      pre_l_d    = pre_sel;
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      s0_d       = 1'b0;
      s1_d       = 1'b0;
      s2_d       = 1'b0;
    end else begin
      if (edge_cnt_q == pre_l_q - ONE) begin
        edge_cnt_d = '0;
        bit_cnt_d  = (bit_cnt_q == last_bit) ? '0 : bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + ONE;
      end

      // s2 is captured at half+1, so the vote at half+2 sees all three registered samples
      if (bus.dat_samp_en) begin
        if (edge_cnt_q == half - ONE) s0_d = bus.RX_IN;
        if (edge_cnt_q == half)       s1_d = bus.RX_IN;
        if (edge_cnt_q == half + ONE) s2_d = bus.RX_IN;
        if (edge_cnt_q == half + TWO) begin
          sampled_bit_d = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
          samp_valid_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre_l_q       <= PRE_MIN;
      edge_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      sampled_bit_q <= 1'b0;
      samp_valid_q  <= 1'b0;
    end else begin
      pre_l_q       <= pre_l_d;
      edge_cnt_q    <= edge_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      sampled_bit_q <= sampled_bit_d;
      samp_valid_q  <= samp_valid_d;
    end
  end

  assign bus.edge_cnt    = edge_cnt_q;
  assign bus.bit_cnt     = bit_cnt_q;
  assign bus.sampled_bit = sampled_bit_q;
  assign bus.samp_valid  = samp_valid_q;
endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Directed bench for rx_edge_bit_sampler: counter sequencing, majority vote,
// prescale latching, reset priority and sample-enable gating.
module tb_rx_edge_bit_sampler;
  logic clk = 1'b0;
  logic rst = 1'b1;

  rx_edge_bit_sampler_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus ();

  rx_edge_bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          exp_e    = 0;
  int          exp_b    = 0;
  int          max_b    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enable-low cycle: counters clear and prescale is latched.
  task automatic restart(input int pre_in);
    bus.enable   = 1'b0;
    bus.prescale = 6'(pre_in);
    tick();
    check("restart_edge", 32'(bus.edge_cnt), 0);
    check("restart_bit", 32'(bus.bit_cnt), 0);
    check("restart_valid", 32'(bus.samp_valid), 0);
    exp_e = 0;
    exp_b = 0;
    max_b = 0;
    bus.enable = 1'b1;
  endtask

  // Runs n enabled cycles; RX_IN is low on bit zb for edges zlo..zhi, high otherwise.
  task automatic run(input int n, input int pre, input int last, input int zb,
                     input int zlo, input int zhi, input logic zval, input logic den);
    int pe;
    int pb;
    logic ev;
    for (int k = 0; k < n; k++) begin
      bus.dat_samp_en = den;
      bus.RX_IN = (exp_b == zb && exp_e >= zlo && exp_e <= zhi) ? 1'b0 : 1'b1;
      pe = exp_e;
      pb = exp_b;
      tick();
      if (pe == pre - 1) begin
        exp_e = 0;
        exp_b = (pb == last) ? 0 : pb + 1;
      end else begin
        exp_e = pe + 1;
      end
      if (exp_b > max_b) max_b = exp_b;
      check("edge_cnt", 32'(bus.edge_cnt), 32'(exp_e));
      check("bit_cnt", 32'(bus.bit_cnt), 32'(exp_b));
      ev = den && (pe == pre / 2 + 2);
      check("samp_valid", 32'(bus.samp_valid), 32'(ev));
      if (ev) check("sampled_bit", 32'(bus.sampled_bit), (pb == zb) ? 32'(zval) : 32'd1);
    end
  endtask

  initial begin
    bus.RX_IN       = 1'b1;
    bus.enable      = 1'b1;
    bus.dat_samp_en = 1'b1;
    bus.PAR_EN      = 1'b0;
    bus.prescale    = 6'd8;

    tick();
    check("rst_edge", 32'(bus.edge_cnt), 0);
    check("rst_bit", 32'(bus.bit_cnt), 0);
    check("rst_sampled", 32'(bus.sampled_bit), 0);
    check("rst_valid", 32'(bus.samp_valid), 0);

    // Straight out of reset with enable high: pre_l is 8
    rst = 1'b0;
    run(80, 8, 9, -1, 0, 0, 1'b1, 1'b1);
    check("wrap80_bit", 32'(bus.bit_cnt), 0);
    check("max_bit_noparity", 32'(max_b), 9);

    // Parity frame, single low sample at mid-bit is out-voted
    bus.PAR_EN = 1'b1;
    restart(16);
    run(176, 16, 10, 3, 8, 8, 1'b1, 1'b1);
    check("max_bit_parity", 32'(max_b), 10);
    check("parity_wrap_bit", 32'(bus.bit_cnt), 0);

    // Three low samples around mid-bit at prescale 32
    bus.PAR_EN = 1'b0;
    restart(32);
    run(320, 32, 9, 2, 15, 17, 1'b0, 1'b1);

    // Two of three low samples
    restart(16);
    run(112, 16, 9, 5, 7, 8, 1'b0, 1'b1);

    // prescale change while enabled is ignored until enable drops
    restart(8);
    bus.prescale = 6'd16;
    run(24, 8, 9, -1, 0, 0, 1'b1, 1'b1);
    restart(16);
    run(40, 16, 9, -1, 0, 0, 1'b1, 1'b1);

    // PAR_EN raised mid-frame extends the frame at the next wrap decision
    restart(8);
    run(64, 8, 9, -1, 0, 0, 1'b1, 1'b1);
    bus.PAR_EN = 1'b1;
    run(24, 8, 10, -1, 0, 0, 1'b1, 1'b1);
    check("par_mid_bit", 32'(bus.bit_cnt), 0);
    bus.PAR_EN = 1'b0;

    // Abort mid-bit before the vote edge: no strobe
    restart(8);
    run(5, 8, 9, 0, 0, 7, 1'b0, 1'b1);
    restart(8);

    // Reset mid-frame with enable held high
    run(43, 8, 9, -1, 0, 0, 1'b1, 1'b1);
    check("pre_rst_bit", 32'(bus.bit_cnt), 5);
    check("pre_rst_edge", 32'(bus.edge_cnt), 3);
    rst = 1'b1;
    tick();
    check("midrst_edge", 32'(bus.edge_cnt), 0);
    check("midrst_bit", 32'(bus.bit_cnt), 0);
    check("midrst_sampled", 32'(bus.sampled_bit), 0);
    check("midrst_valid", 32'(bus.samp_valid), 0);
    rst = 1'b0;
    bus.prescale = 6'd4;
    exp_e = 0;
    exp_b = 0;
    run(20, 8, 9, -1, 0, 0, 1'b1, 1'b1);
    restart(4);
    run(16, 8, 9, -1, 0, 0, 1'b1, 1'b1);

    // Sampling disabled for a whole frame: counters run, no strobe, value held
    restart(8);
    run(80, 8, 9, 4, 0, 7, 1'b0, 1'b0);
    check("held_sampled", 32'(bus.sampled_bit), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_edge_bit_sampler.md
RX_EDGE_BIT_SAMPLER -- requirements
Module: rx_edge_bit_sampler

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of prescale and edge_cnt.
REQ-002 SHALL have parameter BIT_CNT_W, default 4, width of bit_cnt.
REQ-003 SHALL have port CLK, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port RX_IN, input, 1, serial line, already synchronous to CLK, idle high.
REQ-006 SHALL have port enable, input, 1, frame-active from the RX FSM.
REQ-007 SHALL have port dat_samp_en, input, 1, permits capture of RX_IN samples.
REQ-008 SHALL have port PAR_EN, input, 1, frame carries a parity bit.
REQ-009 SHALL have port prescale, input, PRESCALE_W, oversampling clocks per bit.
REQ-010 SHALL have port edge_cnt, output, PRESCALE_W, clock index within the current bit.
REQ-011 SHALL have port bit_cnt, output, BIT_CNT_W, bit index within the frame.
REQ-012 SHALL have port sampled_bit, output, 1, majority-voted bit value.
REQ-013 SHALL have port samp_valid, output, 1, one-cycle strobe marking sampled_bit update.

Function
REQ-014 SHALL hold internal pre_l; pre_l loads max(prescale, 8) every cycle enable=0, holds while enable=1.
REQ-015 SHALL use half = pre_l >> 1; prescale below 8 treated as 8; values >= 8 accepted as-is.
REQ-016 enable=0: edge_cnt<=0, bit_cnt<=0, sample registers<=0, samp_valid<=0; sampled_bit holds.
REQ-017 enable=1 and edge_cnt != pre_l-1: edge_cnt<=edge_cnt+1; bit_cnt holds.
REQ-018 enable=1 and edge_cnt == pre_l-1: edge_cnt<=0; bit_cnt<=bit_cnt+1, or 0 if bit_cnt == last.
REQ-019 last = 10 when PAR_EN=1 (start, 8 data, parity, stop), 9 when PAR_EN=0; bit 0 = start bit.
REQ-020 bit_cnt wrap to 0 after stop SHALL occur with enable still 1; next frame counts from edge 0 without a gap.
REQ-021 enable=1 and dat_samp_en=1: capture RX_IN into s0 at edge_cnt==half-1, s1 at half, s2 at half+1.
REQ-022 Cycle with edge_cnt==half+2, enable=1, dat_samp_en=1: sampled_bit<=majority(s0,s1,s2); samp_valid<=1.
REQ-023 samp_valid SHALL be 0 in every other cycle; exactly one pulse per bit period while sampling enabled.
REQ-024 dat_samp_en=0 at a capture edge: that sample register holds its old value; no samp_valid if 0 at half+2.
REQ-025 enable dropped mid-bit: counters abort and clear on next edge; no samp_valid for the aborted bit.
REQ-026 PAR_EN changes mid-frame: the new value applies at the next bit_cnt wrap decision; no other effect.
REQ-027 Counter arithmetic SHALL be modulo-free: edge_cnt never exceeds pre_l-1; bit_cnt never exceeds 10.

Reset
REQ-028 RST=1 at a rising CLK edge: edge_cnt=0, bit_cnt=0, sampled_bit=0, samp_valid=0, s0..s2=0, pre_l=8.
REQ-029 RST SHALL take priority over enable and all other inputs, including mid-frame.
REQ-030 First cycle after RST deasserts with enable=1: edge_cnt 0->1 using pre_l=8 unless enable was first low.

Verification
REQ-031 prescale=8, PAR_EN=0, enable held 80 cycles -> edge_cnt 0..7 repeating, bit_cnt 0..9 then 0, samp_valid on cycles with edge_cnt==6.
REQ-032 prescale=16, PAR_EN=1, RX_IN low only at edge_cnt==8 of bit 3 -> sampled_bit=1 for bit 3 (2-of-3 majority), bit_cnt reaches 10 then wraps to 0.
REQ-033 prescale=32, bit 2 RX_IN=0 for edge 15..17 -> sampled_bit=0, samp_valid at edge_cnt==18 only.
REQ-034 enable=1 and prescale changed 8->16 mid-frame -> wrap stays at 7 until enable low one cycle, then wraps at 15.
REQ-035 RST=1 at bit_cnt=5, edge_cnt=3 -> next cycle all outputs 0; prescale=4 afterwards -> behaves as 8.
REQ-036 dat_samp_en=0 for whole frame, prescale=8 -> counters run normally, samp_valid never asserts, sampled_bit unchanged.
